// File: rtl/z_baseline_remover.sv
// Removes the slow gravity/orientation baseline from raw Z samples with a shift-based EMA and emits |z - baseline|.
// Latency 2 cycles, 1 sample/cycle; no backpressure. Output is suppressed during warm-up and after a dropout.
module z_baseline_remover #(
  parameter int ALPHA_SHIFT    = 6,
  parameter int WARMUP_SAMPLES = 64,
  parameter int STALE_CYCLES   = 10_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        raw_valid,
  input  logic [15:0] z_raw,
  output logic        dyn_valid,
  output logic [15:0] z_dynamic_abs,
  output logic [15:0] z_baseline,
  output logic        baseline_ready,
  output logic        sensor_stale
);

  localparam int ACC_W = 17 + ALPHA_SHIFT;
  localparam int CNT_W = $clog2(WARMUP_SAMPLES + 1);
  localparam int GAP_W = $clog2(STALE_CYCLES + 1);
  localparam logic [CNT_W-1:0] WARM_MAX = CNT_W'(WARMUP_SAMPLES);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(STALE_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(STALE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_WARMUP = 2'd1,
    S_RUN    = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic signed [ACC_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0]        samp_cnt, samp_cnt_nxt;
  logic [GAP_W-1:0]        gap_cnt, gap_cnt_nxt;
  logic                    stale_nxt;
  logic                    emit;

  logic signed [ACC_W-1:0] x_ext;
  logic signed [ACC_W-1:0] acc_shr;
  logic signed [ACC_W-1:0] acc_ema;
  logic signed [ACC_W-1:0] acc_seed;
  logic signed [16:0]      z_ext;
  logic signed [16:0]      base_ext;
  logic signed [16:0]      diff;

  logic                    s1_vld;
  logic signed [16:0]      s1_diff;
  logic [15:0]             s1_abs;

  assign x_ext    = {{(ACC_W-16){z_raw[15]}}, z_raw};
  assign acc_shr  = acc >>> ALPHA_SHIFT;
  assign acc_ema  = acc + x_ext - acc_shr;
  assign acc_seed = x_ext <<< ALPHA_SHIFT;

  // The difference is taken against the baseline as it stood before this sample folds in.
  assign z_ext    = {z_raw[15], z_raw};
  assign base_ext = {acc[ALPHA_SHIFT+15], acc[ALPHA_SHIFT +: 16]};
  assign diff     = z_ext - base_ext;

  assign z_baseline     = acc[ALPHA_SHIFT +: 16];
  assign baseline_ready = (state == S_RUN);

  always_comb begin
    state_nxt    = state;
    acc_nxt      = acc;
    samp_cnt_nxt = samp_cnt;
    gap_cnt_nxt  = gap_cnt;
    stale_nxt    = sensor_stale;
    emit         = 1'b0;

    if (raw_valid) begin
      // A sample arriving on the dropout cycle wins: the gap simply restarts.
      gap_cnt_nxt = '0;
      case (state)
        S_INIT: begin
          acc_nxt      = acc_seed;
          samp_cnt_nxt = CNT_W'(1);
          stale_nxt    = 1'b0;
          state_nxt    = (WARMUP_SAMPLES == 1) ? S_RUN : S_WARMUP;
        end
        S_WARMUP: begin
          acc_nxt      = acc_ema;
          samp_cnt_nxt = samp_cnt + 1'b1;
          if (samp_cnt + 1'b1 == WARM_MAX) begin
            state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          acc_nxt = acc_ema;
          emit    = 1'b1;
        end
        default: begin
          state_nxt = S_INIT;
        end
      endcase
    end else if (gap_cnt != GAP_MAX) begin
      gap_cnt_nxt = gap_cnt + 1'b1;
      if (gap_cnt == GAP_LAST) begin
        state_nxt    = S_INIT;
        samp_cnt_nxt = '0;
        stale_nxt    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_INIT;
      acc          <= '0;
      samp_cnt     <= '0;
      gap_cnt      <= '0;
      sensor_stale <= 1'b0;
    end else begin
      state        <= state_nxt;
      acc          <= acc_nxt;
      samp_cnt     <= samp_cnt_nxt;
      gap_cnt      <= gap_cnt_nxt;
      sensor_stale <= stale_nxt;
    end
  end

  // Stage 1 is independent of the FSM so entries already flagged still drain after a dropout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld  <= 1'b0;
      s1_diff <= '0;
    end else begin
      s1_vld <= emit;
      if (raw_valid) begin
        s1_diff <= diff;
      end
    end
  end

  // Two's-complement magnitude; |d| never exceeds 65535 so the low 16 bits are exact.
  assign s1_abs = (s1_diff[15:0] ^ {16{s1_diff[16]}}) + {15'd0, s1_diff[16]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dyn_valid     <= 1'b0;
      z_dynamic_abs <= '0;
    end else begin
      dyn_valid <= s1_vld;
      if (s1_vld) begin
        z_dynamic_abs <= s1_abs;
      end
    end
  end

endmodule

// File: tb/tb_z_baseline_remover.sv
// Bench for z_baseline_remover: directed scenarios plus randomized traffic against a sample-level reference model.
module tb_z_baseline_remover;

  localparam int SH    = 6;
  localparam int W     = 4;
  localparam int STALE = 100;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        raw_valid = 1'b0;
  logic [15:0] z_raw = '0;
  wire         dyn_valid;
  wire  [15:0] z_dynamic_abs;
  wire  [15:0] z_baseline;
  wire         baseline_ready;
  wire         sensor_stale;

  int checks = 0;
  int errors = 0;

  z_baseline_remover #(
    .ALPHA_SHIFT   (SH),
    .WARMUP_SAMPLES(W),
    .STALE_CYCLES  (STALE)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .raw_valid     (raw_valid),
    .z_raw         (z_raw),
    .dyn_valid     (dyn_valid),
    .z_dynamic_abs (z_dynamic_abs),
    .z_baseline    (z_baseline),
    .baseline_ready(baseline_ready),
    .sensor_stale  (sensor_stale)
  );

  always #5 clk = ~clk;

  // Reference model: samples since seed, EMA accumulator, idle gap, and scheduled outputs.
  typedef struct {
    int due;
    int val;
  } pend_t;

  longint m_acc;
  int     m_cnt;
  int     m_gap;
  bit     m_stale;
  bit     e_dv;
  int     e_abs;
  int     cyc;
  pend_t  pend[$];

  function automatic void model_reset();
    m_acc   = 0;
    m_cnt   = 0;
    m_gap   = 0;
    m_stale = 0;
    e_dv    = 0;
    e_abs   = 0;
    cyc     = 0;
    pend.delete();
  endfunction

  function automatic void model_step(bit v, int x);
    pend_t  p;
    longint base;
    int     d;
    cyc  = cyc + 1;
    e_dv = 0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      p     = pend.pop_front();
      e_dv  = 1;
      e_abs = p.val;
    end
    if (v) begin
      m_gap = 0;
      if (m_cnt == 0) begin
        m_acc   = longint'(x) * (64'sd1 <<< SH);
        m_cnt   = 1;
        m_stale = 0;
      end else begin
        base = m_acc >>> SH;
        d    = x - int'(base);
        if (m_cnt >= W) begin
          p.due = cyc + 1;
          p.val = (d < 0) ? -d : d;
          pend.push_back(p);
        end
        m_acc = m_acc + x - base;
        if (m_cnt < W) m_cnt = m_cnt + 1;
      end
    end else if (m_gap < STALE) begin
      m_gap = m_gap + 1;
      if (m_gap == STALE) begin
        m_cnt   = 0;
        m_stale = 1;
      end
    end
  endfunction

  function automatic logic [15:0] m_base();
    longint b;
    b = m_acc >>> SH;
    return 16'(b);
  endfunction

  // Called at a negedge; returns at the next negedge with the model advanced in step.
  task automatic tick(input bit v, input int x);
    raw_valid = v;
    z_raw     = 16'(x);
    @(posedge clk);
    model_step(v, x);
    @(negedge clk);
    raw_valid = 1'b0;
  endtask

  task automatic apply_reset();
    reset_n   = 1'b0;
    raw_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    #1;
    checks++; if (dyn_valid !== 1'b0)       begin errors++; $display("FAIL reset_dyn_valid got %0d expected 0", dyn_valid); end
    checks++; if (z_dynamic_abs !== 16'd0)  begin errors++; $display("FAIL reset_abs got %0d expected 0", z_dynamic_abs); end
    checks++; if (z_baseline !== 16'd0)     begin errors++; $display("FAIL reset_baseline got %0d expected 0", z_baseline); end
    checks++; if (baseline_ready !== 1'b0)  begin errors++; $display("FAIL reset_ready got %0d expected 0", baseline_ready); end
    checks++; if (sensor_stale !== 1'b0)    begin errors++; $display("FAIL reset_stale got %0d expected 0", sensor_stale); end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_warmup_emit();
    apply_reset();
    for (int i = 1; i <= 5; i++) begin
      tick(1, 1000);
      checks++; if (dyn_valid !== 1'b0) begin errors++; $display("FAIL warmup_no_emit sample %0d got %0d expected 0", i, dyn_valid); end
      checks++; if (baseline_ready !== (i >= W)) begin errors++; $display("FAIL warmup_ready sample %0d got %0d expected %0d", i, baseline_ready, (i >= W)); end
    end
    tick(0, 0);
    checks++; if (dyn_valid !== 1'b1)      begin errors++; $display("FAIL first_emit_valid got %0d expected 1", dyn_valid); end
    checks++; if (z_dynamic_abs !== 16'd0) begin errors++; $display("FAIL first_emit_abs got %0d expected 0", z_dynamic_abs); end
    checks++; if (z_baseline !== 16'd1000) begin errors++; $display("FAIL first_emit_baseline got %0d expected 1000", z_baseline); end
    tick(0, 0);
    checks++; if (dyn_valid !== 1'b0)      begin errors++; $display("FAIL single_pulse got %0d expected 0", dyn_valid); end
  endtask

  task automatic test_ema_step();
    tick(1, 1400);
    checks++; if (z_baseline !== 16'd1006) begin errors++; $display("FAIL ema_baseline got %0d expected 1006", z_baseline); end
    tick(1, 1400);
    checks++; if (dyn_valid !== 1'b1 || z_dynamic_abs !== 16'd400) begin errors++; $display("FAIL ema_first got v=%0d abs=%0d expected v=1 abs=400", dyn_valid, z_dynamic_abs); end
    tick(0, 0);
    checks++; if (dyn_valid !== 1'b1 || z_dynamic_abs !== 16'd394) begin errors++; $display("FAIL ema_second got v=%0d abs=%0d expected v=1 abs=394", dyn_valid, z_dynamic_abs); end
  endtask

  task automatic test_extremes();
    apply_reset();
    for (int i = 0; i < W; i++) tick(1, 1000);
    tick(1, -200);
    tick(0, 0);
    checks++; if (dyn_valid !== 1'b1 || z_dynamic_abs !== 16'd1200) begin errors++; $display("FAIL neg_diff got v=%0d abs=%0d expected v=1 abs=1200", dyn_valid, z_dynamic_abs); end
    apply_reset();
    for (int i = 0; i < W; i++) tick(1, -32768);
    checks++; if (z_baseline !== 16'h8000) begin errors++; $display("FAIL min_baseline got %0d expected 32768", z_baseline); end
    tick(1, 32767);
    tick(0, 0);
    checks++; if (dyn_valid !== 1'b1 || z_dynamic_abs !== 16'd65535) begin errors++; $display("FAIL full_swing got v=%0d abs=%0d expected v=1 abs=65535", dyn_valid, z_dynamic_abs); end
  endtask

  task automatic test_stale();
    apply_reset();
    for (int i = 0; i < W; i++) tick(1, 1000);
    for (int k = 1; k <= STALE; k++) begin
      tick(0, 0);
      if (k == STALE - 1) begin
        checks++; if (sensor_stale !== 1'b0 || baseline_ready !== 1'b1) begin errors++; $display("FAIL stale_early got stale=%0d ready=%0d expected 0/1", sensor_stale, baseline_ready); end
      end
    end
    checks++; if (sensor_stale !== 1'b1 || baseline_ready !== 1'b0) begin errors++; $display("FAIL stale_set got stale=%0d ready=%0d expected 1/0", sensor_stale, baseline_ready); end
    checks++; if (z_baseline !== 16'd1000) begin errors++; $display("FAIL stale_baseline_held got %0d expected 1000", z_baseline); end
    for (int i = 1; i <= W; i++) begin
      tick(1, 500);
      checks++; if (dyn_valid !== 1'b0 || sensor_stale !== 1'b0) begin errors++; $display("FAIL reseed sample %0d got v=%0d stale=%0d expected 0/0", i, dyn_valid, sensor_stale); end
    end
    checks++; if (baseline_ready !== 1'b1 || z_baseline !== 16'd500) begin errors++; $display("FAIL reseed_ready got ready=%0d base=%0d expected 1/500", baseline_ready, z_baseline); end
    tick(1, 600);
    for (int k = 1; k <= STALE - 1; k++) begin
      tick(0, 0);
      if (k == 1) begin
        checks++; if (dyn_valid !== 1'b1 || z_dynamic_abs !== 16'd100) begin errors++; $display("FAIL reseed_emit got v=%0d abs=%0d expected v=1 abs=100", dyn_valid, z_dynamic_abs); end
      end
    end
    tick(1, 600);
    checks++; if (sensor_stale !== 1'b0 || baseline_ready !== 1'b1) begin errors++; $display("FAIL gap99_race got stale=%0d ready=%0d expected 0/1", sensor_stale, baseline_ready); end
    tick(0, 0);
    checks++; if (dyn_valid !== e_dv || z_dynamic_abs !== 16'(e_abs) || e_dv !== 1'b1) begin errors++; $display("FAIL gap99_emit got v=%0d abs=%0d expected v=%0d abs=%0d", dyn_valid, z_dynamic_abs, e_dv, e_abs); end
  endtask

  task automatic test_back_to_back();
    int pulses;
    int first;
    int last;
    int x;
    pulses = 0;
    first  = -1;
    last   = -1;
    apply_reset();
    for (int i = 0; i < W; i++) tick(1, 2000);
    for (int i = 0; i < 22; i++) begin
      x = (i < 20) ? (int'($urandom_range(0, 8000)) - 4000) : 0;
      tick(i < 20, x);
      if (dyn_valid === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
        last = i;
      end
      checks++; if (dyn_valid !== e_dv || z_dynamic_abs !== 16'(e_abs)) begin errors++; $display("FAIL b2b_seq idx %0d got v=%0d abs=%0d expected v=%0d abs=%0d", i, dyn_valid, z_dynamic_abs, e_dv, e_abs); end
    end
    checks++; if (pulses != 20 || last - first != 19) begin errors++; $display("FAIL b2b_count got pulses=%0d span=%0d expected 20/19", pulses, last - first); end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    for (int i = 0; i < W; i++) tick(1, 1000);
    tick(1, 1234);
    reset_n = 1'b0;
    #1;
    checks++; if (dyn_valid !== 1'b0 || z_dynamic_abs !== 16'd0 || z_baseline !== 16'd0) begin errors++; $display("FAIL midreset_outputs got v=%0d abs=%0d base=%0d expected 0/0/0", dyn_valid, z_dynamic_abs, z_baseline); end
    checks++; if (baseline_ready !== 1'b0 || sensor_stale !== 1'b0) begin errors++; $display("FAIL midreset_flags got ready=%0d stale=%0d expected 0/0", baseline_ready, sensor_stale); end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      tick(0, 0);
      checks++; if (dyn_valid !== 1'b0) begin errors++; $display("FAIL midreset_drain cycle %0d got %0d expected 0", i, dyn_valid); end
    end
  endtask

  task automatic test_random();
    int x;
    int base;
    int idle;
    bit v;
    apply_reset();
    base = int'($urandom_range(0, 20000)) - 10000;
    idle = 0;
    for (int i = 0; i < 1500; i++) begin
      if (idle > 0) begin
        v    = 0;
        idle = idle - 1;
      end else begin
        v = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 199) == 0) idle = int'($urandom_range(90, 110));
      end
      if ($urandom_range(0, 49) == 0) x = int'($urandom_range(0, 65535)) - 32768;
      else x = base + int'($urandom_range(0, 4000)) - 2000;
      tick(v, x);
      checks++;
      if (dyn_valid !== e_dv || (e_dv && z_dynamic_abs !== 16'(e_abs)) ||
          z_baseline !== m_base() || baseline_ready !== (m_cnt >= W) || sensor_stale !== m_stale) begin
        errors++;
        $display("FAIL random cyc %0d got v=%0d abs=%0d base=%0d rdy=%0d stale=%0d expected v=%0d abs=%0d base=%0d rdy=%0d stale=%0d",
                 i, dyn_valid, z_dynamic_abs, z_baseline, baseline_ready, sensor_stale,
                 e_dv, e_abs, m_base(), (m_cnt >= W), m_stale);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_warmup_emit();
    test_ema_step();
    test_extremes();
    test_stale();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
